// File: rtl/intc_hwint_if.sv
// intc_hwint_if: memory-mapped register bus for the intc_hwint interrupt controller.
// master = bus initiator (CPU side), slave = intc_hwint register window.
interface intc_hwint_if;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output we, output addr, output wdata, input rdata);
    modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/intc_hwint.sv
// intc_hwint: six-source interrupt controller feeding CP0 HWInt[5:0].
// Per-source edge/level conditioning, pending latch with W1C, output mask,
// lowest-index priority report and a saturating lost-edge counter.
// Optional feature macro: INTC_SYNC_EN -- when defined, each irq_in line passes
// through a 2-flop synchronizer before conditioning (for asynchronous lines).
module intc_hwint (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      irq_in,
    intc_hwint_if.slave     bus,
    output logic [5:0]      hw_int,
    output logic            irq_any
);

    localparam int NSRC = 6;

    localparam logic [1:0] ADDR_MODE    = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // Index of the lowest set bit, or 7 when no bit is set.
    function automatic logic [2:0] lowest_set(input logic [NSRC-1:0] v);
        logic [2:0] idx;
        idx = 3'd7;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [NSRC-1:0] s_s;
    logic [NSRC-1:0] prev_q,    prev_d;
    logic [NSRC-1:0] mode_q,    mode_d;
    logic [NSRC-1:0] mask_q,    mask_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [15:0]     lost_q,    lost_d;

    logic [NSRC-1:0] rise_s;
    logic [NSRC-1:0] w1c_s;
    logic            lost_hit_s;
    logic            wr_mode_s, wr_mask_s, wr_pend_s, wr_status_s;
    logic [2:0]      prio_s;
    logic            wdata_unused_s;

    assign wdata_unused_s = ^bus.wdata[31:NSRC];

`ifdef INTC_SYNC_EN
    logic [NSRC-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for asynchronous request lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 6'd0;
            sync2_q <= 6'd0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign s_s = sync2_q;
`else
    assign s_s = irq_in;
`endif

    // Bus write decode and next-state computation for all registers.
    always_comb begin
        wr_mode_s   = bus.we && (bus.addr == ADDR_MODE);
        wr_mask_s   = bus.we && (bus.addr == ADDR_MASK);
        wr_pend_s   = bus.we && (bus.addr == ADDR_PENDING);
        wr_status_s = bus.we && (bus.addr == ADDR_STATUS);

        // Rises only matter for edge-mode sources; MODE in effect is the registered one.
        rise_s     = s_s & ~prev_q & mode_q;
        lost_hit_s = |(rise_s & pending_q);

        if (wr_pend_s) begin
            w1c_s = bus.wdata[NSRC-1:0];
        end else begin
            w1c_s = 6'd0;
        end

        // Edge bits: set wins over W1C. Level bits: follow the sample.
        pending_d = (mode_q & ((pending_q & ~w1c_s) | rise_s)) | (~mode_q & s_s);
        prev_d    = s_s;

        if (wr_mode_s) begin
            mode_d = bus.wdata[NSRC-1:0];
        end else begin
            mode_d = mode_q;
        end

        if (wr_mask_s) begin
            mask_d = bus.wdata[NSRC-1:0];
        end else begin
            mask_d = mask_q;
        end

        // STATUS write clears LOST and takes precedence over a same-cycle increment.
        if (wr_status_s) begin
            lost_d = 16'd0;
        end else if (lost_hit_s && (lost_q != 16'hFFFF)) begin
            lost_d = lost_q + 16'd1;
        end else begin
            lost_d = lost_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q    <= 6'd0;
            mode_q    <= 6'd0;
            mask_q    <= 6'd0;
            pending_q <= 6'd0;
            lost_q    <= 16'd0;
        end else begin
            prev_q    <= prev_d;
            mode_q    <= mode_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
            lost_q    <= lost_d;
        end
    end

    // Masked interrupt outputs; no combinational path from irq_in.
    always_comb begin
        hw_int  = pending_q & mask_q;
        irq_any = |hw_int;
        prio_s  = lowest_set(hw_int);
    end

    // Combinational register read mux.
    always_comb begin
        case (bus.addr)
            ADDR_MODE:    bus.rdata = {26'd0, mode_q};
            ADDR_MASK:    bus.rdata = {26'd0, mask_q};
            ADDR_PENDING: bus.rdata = {26'd0, pending_q};
            ADDR_STATUS:  bus.rdata = {lost_q, 12'd0, irq_any, prio_s};
            default:      bus.rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_intc_hwint.sv
// tb_intc_hwint: directed test-plan steps plus a randomized phase, all checked
// against a behavioural reference model of the interrupt controller.
`timescale 1ns/100ps
module tb_intc_hwint;

    logic       clk;
    logic       reset;
    logic [5:0] irq_in;
    logic [5:0] hw_int;
    logic       irq_any;

    intc_hwint_if bus ();

    intc_hwint dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .bus     (bus),
        .hw_int  (hw_int),
        .irq_any (irq_any)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [5:0]  m_mode, m_mask, m_pend, m_prev, m_s1, m_s2;
    logic [15:0] m_lost;

    task automatic m_reset();
        m_mode = 6'd0; m_mask = 6'd0; m_pend = 6'd0;
        m_prev = 6'd0; m_s1 = 6'd0; m_s2 = 6'd0; m_lost = 16'd0;
    endtask

    function automatic logic [5:0] m_hw();
        return m_pend & m_mask;
    endfunction

    function automatic logic [31:0] m_status();
        logic [5:0] hw;
        int idx;
        hw = m_hw();
        idx = 7;
        for (int i = 0; i < 6; i++) begin
            if (hw[i] && idx == 7) idx = i;
        end
        return {m_lost, 12'd0, (hw != 6'd0), 3'(idx)};
    endfunction

    function automatic logic [31:0] m_reg(input int a);
        case (a)
            0: return {26'd0, m_mode};
            1: return {26'd0, m_mask};
            2: return {26'd0, m_pend};
            default: return m_status();
        endcase
    endfunction

    // Advance the model by one clock using the currently driven inputs, then
    // step the DUT through the same edge and settle 1 ns after it.
    task automatic cycle();
        logic [5:0] smp, nxt;
        bit hit;
        bit rise;
`ifdef INTC_SYNC_EN
        smp = m_s2;
`else
        smp = irq_in;
`endif
        hit = 1'b0;
        nxt = m_pend;
        for (int i = 0; i < 6; i++) begin
            if (m_mode[i]) begin
                rise = smp[i] && !m_prev[i];
                if (rise && m_pend[i]) hit = 1'b1;
                if (bus.we && bus.addr == 2'd2 && bus.wdata[i]) nxt[i] = 1'b0;
                if (rise) nxt[i] = 1'b1;
            end else begin
                nxt[i] = smp[i];
            end
        end
        m_pend = nxt;
        if (bus.we && bus.addr == 2'd3) m_lost = 16'd0;
        else if (hit && m_lost != 16'hFFFF) m_lost = m_lost + 16'd1;
        if (bus.we && bus.addr == 2'd0) m_mode = bus.wdata[5:0];
        if (bus.we && bus.addr == 2'd1) m_mask = bus.wdata[5:0];
        m_prev = smp;
        m_s2 = m_s1;
        m_s1 = irq_in;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.we = 1'b1;
        bus.addr = a;
        bus.wdata = d;
        cycle();
        bus.we = 1'b0;
        bus.wdata = 32'd0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] d;
        check({tag, ".hw_int"}, {26'd0, hw_int}, {26'd0, m_hw()});
        check({tag, ".irq_any"}, {31'd0, irq_any}, {31'd0, (m_hw() != 6'd0)});
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            check($sformatf("%s.reg%0d", tag, a), d, m_reg(a));
        end
    endtask

    initial begin
        logic [31:0] d;
        reset = 1'b1;
        irq_in = 6'd0;
        bus.we = 1'b0;
        bus.addr = 2'd0;
        bus.wdata = 32'd0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values
        check_all("reset");
        rd(2'd3, d);
        check("reset.status", d, 32'h0000_0007);

        // Edge latch and clear
        wr(2'd0, 32'h3F);
        wr(2'd1, 32'h04);
        irq_in = 6'h04; cycle();
        irq_in = 6'h00;
        check("edge.hw", {26'd0, hw_int}, 32'h04);
        rd(2'd3, d);
        check("edge.status", {28'd0, d[3:0]}, 32'hA);
        check_all("edge");
        wr(2'd2, 32'h04);
        check("edge.w1c", {26'd0, hw_int}, 32'h00);
        check_all("edge_clr");

        // Level follow
        wr(2'd0, 32'h00);
        wr(2'd1, 32'h3F);
        irq_in = 6'h20; cycle();
        check("level.hw", {26'd0, hw_int}, 32'h20);
        wr(2'd2, 32'h20);
        check("level.w1c", {26'd0, hw_int}, 32'h20);
        irq_in = 6'h00; cycle();
        check("level.drop", {26'd0, hw_int}, 32'h00);
        check_all("level");

        // Mask, priority, set-wins
        wr(2'd0, 32'h3F);
        wr(2'd1, 32'h00);
        irq_in = 6'h12; cycle();
        irq_in = 6'h00; cycle();
        check("mask.hw", {26'd0, hw_int}, 32'h00);
        rd(2'd2, d);
        check("mask.pend", d, 32'h12);
        wr(2'd1, 32'h3F);
        check("mask.hw_on", {26'd0, hw_int}, 32'h12);
        rd(2'd3, d);
        check("mask.prio", {29'd0, d[2:0]}, 32'd1);
        irq_in = 6'h02;
        wr(2'd2, 32'h02);
        irq_in = 6'h00;
        rd(2'd2, d);
        check("setwins.pend", d, 32'h12);
        check_all("setwins");
        cycle();

        // LOST counter
        wr(2'd3, 32'h0);
        wr(2'd2, 32'h3F);
        irq_in = 6'h08; cycle();
        irq_in = 6'h00; cycle();
        for (int k = 0; k < 3; k++) begin
            irq_in = 6'h08; cycle();
            irq_in = 6'h00; cycle();
        end
        rd(2'd3, d);
        check("lost.3", {16'd0, d[31:16]}, 32'd3);
        wr(2'd3, 32'h0);
        rd(2'd3, d);
        check("lost.clr", {16'd0, d[31:16]}, 32'd0);
        // Alternate rises on two pending bits so every cycle counts once.
        irq_in = 6'h10; cycle();
        irq_in = 6'h00; cycle();
        for (int k = 0; k < 32'h10001; k++) begin
            irq_in = (k % 2 == 0) ? 6'h08 : 6'h10;
            cycle();
        end
        irq_in = 6'h00; cycle();
        rd(2'd3, d);
        check("lost.sat", {16'd0, d[31:16]}, 32'hFFFF);
        check_all("lost_sat");
        wr(2'd3, 32'h0);

        // Input-to-output latency
        wr(2'd2, 32'h3F);
        irq_in = 6'h00; cycle(); cycle(); cycle();
        irq_in = 6'h01; cycle();
`ifdef INTC_SYNC_EN
        check("lat.n", {31'd0, hw_int[0]}, 32'd0);
        cycle();
        check("lat.n1", {31'd0, hw_int[0]}, 32'd0);
        cycle();
        check("lat.n2", {31'd0, hw_int[0]}, 32'd1);
`else
        check("lat.n", {31'd0, hw_int[0]}, 32'd1);
`endif
        irq_in = 6'h00; cycle(); cycle(); cycle();
        check_all("lat");

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            irq_in = 6'($urandom);
            if ($urandom_range(3, 0) == 0) begin
                wr(2'($urandom_range(3, 0)), $urandom);
            end else begin
                cycle();
            end
            check_all("rand");
        end

        // Mid-cycle reset discards pending state
        wr(2'd0, 32'h3F);
        wr(2'd1, 32'h3F);
        irq_in = 6'h3F; cycle();
        irq_in = 6'h00; cycle();
        check("prerst.hw", {26'd0, hw_int}, 32'h3F);
        #4;
        reset = 1'b1;
        #1;
        check("rst.hw", {26'd0, hw_int}, 32'h00);
        check("rst.any", {31'd0, irq_any}, 32'd0);
        rd(2'd3, d);
        check("rst.status", d, 32'h0000_0007);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        check_all("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
